// File: rtl/reg_arb_pkg.sv
// Shared register arbiter: FSM encoding and write-counter limit.
// Imported by the arbiter top and its interface.
package reg_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_REL  = 2'd2;

  localparam logic [15:0] WR_SAT = 16'hFFFF;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared register arbiter.
// master = requesters/bench, slave = arbiter.
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(N_REQ)
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [IW-1:0]          owner;
  logic [15:0]            wr_count;

  modport master (
    output req,
    output wdata,
    input  gnt,
    input  q,
    input  q_valid,
    input  owner,
    input  wr_count
  );

  modport slave (
    input  req,
    input  wdata,
    output gnt,
    output q,
    output q_valid,
    output owner,
    output wr_count
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin search: first set req at or above ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             found
);

  int          idx;
  logic [IW-1:0] idx_w;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// N-way round-robin arbiter guarding one shared write register.
// IDLE -> LOAD -> RELEASE, one write opportunity per grant.
module shared_reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(N_REQ)
) (
  input logic clk,
  input logic reset,
  shared_reg_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [15:0]      wr_count_q, wr_count_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    win_q, win_d;

  logic [IW-1:0]    pick;
  logic             found;
  logic             req_hit;
  logic [WIDTH-1:0] wsel;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .winner(pick),
    .found (found)
  );

  always_comb begin
    req_hit = 1'b0;
    wsel    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == win_q) begin
        req_hit = bus.req[i];
        wsel    = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    q_d        = q_q;
    q_valid_d  = 1'b0;
    owner_d    = owner_q;
    wr_count_d = wr_count_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = pick;
          gnt_d   = N_REQ'(1) << pick;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // a dropped request aborts the write but still advances ptr
        if (req_hit) begin
          q_d       = wsel;
          owner_d   = win_q;
          q_valid_d = 1'b1;
          if (wr_count_q != WR_SAT)
            wr_count_d = wr_count_q + 16'd1;
        end
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(N_REQ - 1)) ?
                  '0 : win_q + IW'(1);
        state_d = S_REL;
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      owner_q    <= '0;
      wr_count_q <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      owner_q    <= owner_d;
      wr_count_q <= wr_count_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.owner    = owner_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter.
// Drives and samples on the falling edge.
module tb_shared_reg_arbiter;
  import reg_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  shared_reg_arbiter_if #(
    .N_REQ(N),
    .WIDTH(W)
  ) bif ();

  shared_reg_arbiter #(
    .N_REQ(N),
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_g = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("gnt_onehot0",
            32'($onehot0(bif.gnt)), 32'd1);
      check("gnt_only_load",
            32'(bif.gnt == '0 ||
                dut.state_q == S_LOAD), 32'd1);
    end
  end

  task automatic set_wd(input int i,
                        input logic [7:0] v);
    bif.wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bif.req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bif.gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input int idx,
                       input logic [7:0] exp_q,
                       input logic [15:0] exp_cnt,
                       input bit drop);
    bit ok;
    wait_gnt(ok);
    if (!ok) return;
    last_g = cyc;
    check($sformatf("gnt_r%0d", idx),
          32'(bif.gnt), 32'd1 << idx);
    @(negedge clk);
    check("q", 32'(bif.q), 32'(exp_q));
    check("q_valid", 32'(bif.q_valid), 32'd1);
    check("owner", 32'(bif.owner), 32'(idx));
    check("wr_count", 32'(bif.wr_count),
          32'(exp_cnt));
    check("gnt_clr", 32'(bif.gnt), 32'd0);
    if (drop) bif.req[idx] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    bif.req   = '0;
    bif.wdata = '0;

    // single requester
    do_reset();
    mon_en = 1'b1;
    check("rst_gnt", 32'(bif.gnt), 32'd0);
    check("rst_q", 32'(bif.q), 32'd0);
    check("rst_qv", 32'(bif.q_valid), 32'd0);
    check("rst_owner", 32'(bif.owner), 32'd0);
    check("rst_cnt", 32'(bif.wr_count), 32'd0);
    check("rst_ptr", 32'(dut.ptr_q), 32'd0);
    bif.req = 4'b0100;
    set_wd(2, 8'hA5);
    serve(2, 8'hA5, 16'd1, 1'b1);
    set_wd(2, 8'hFF);
    @(negedge clk);
    check("qv_pulse", 32'(bif.q_valid), 32'd0);
    check("q_hold", 32'(bif.q), 32'hA5);
    @(negedge clk);
    check("q_hold2", 32'(bif.q), 32'hA5);

    // full contention
    do_reset();
    for (int i = 0; i < N; i++)
      set_wd(i, 8'(8'h10 + i));
    bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      prev = last_g;
      serve(k % N, 8'(8'h10 + k % N),
            16'(k + 1), 1'b0);
      if (k > 0)
        check("spacing", 32'(last_g - prev), 32'd3);
    end
    bif.req = '0;

    // pointer wrap
    do_reset();
    bif.req = 4'b1000;
    set_wd(3, 8'h33);
    serve(3, 8'h33, 16'd1, 1'b1);
    bif.req = 4'b1001;
    set_wd(0, 8'h44);
    serve(0, 8'h44, 16'd2, 1'b1);
    serve(3, 8'h33, 16'd3, 1'b1);

    // abort
    do_reset();
    bif.req = 4'b0001;
    set_wd(0, 8'h55);
    serve(0, 8'h55, 16'd1, 1'b1);
    bif.req = 4'b0010;
    set_wd(1, 8'h66);
    wait_gnt(ok);
    check("ab_gnt", 32'(bif.gnt), 32'b0010);
    bif.req[1] = 1'b0;
    @(negedge clk);
    check("ab_q", 32'(bif.q), 32'h55);
    check("ab_qv", 32'(bif.q_valid), 32'd0);
    check("ab_cnt", 32'(bif.wr_count), 32'd1);
    check("ab_owner", 32'(bif.owner), 32'd0);
    check("ab_ptr", 32'(dut.ptr_q), 32'd2);
    bif.req = 4'b0011;
    set_wd(0, 8'h57);
    serve(0, 8'h57, 16'd2, 1'b1);
    serve(1, 8'h66, 16'd3, 1'b1);

    // reset while in LOAD
    do_reset();
    bif.req = 4'b0001;
    set_wd(0, 8'h3C);
    wait_gnt(ok);
    check("mr_gnt", 32'(bif.gnt), 32'b0001);
    reset = 1'b1;
    @(negedge clk);
    check("mr_q", 32'(bif.q), 32'd0);
    check("mr_gnt0", 32'(bif.gnt), 32'd0);
    check("mr_qv", 32'(bif.q_valid), 32'd0);
    check("mr_ptr", 32'(dut.ptr_q), 32'd0);
    check("mr_state", 32'(dut.state_q),
          32'(S_IDLE));
    check("mr_cnt", 32'(bif.wr_count), 32'd0);
    reset   = 1'b0;
    bif.req = '0;
    @(negedge clk);
    check("mr_qv2", 32'(bif.q_valid), 32'd0);

    // saturation
    do_reset();
    force dut.wr_count_d = 16'hFFFE;
    @(posedge clk);
    #1 release dut.wr_count_d;
    @(negedge clk);
    check("sat_pre", 32'(bif.wr_count), 32'hFFFE);
    bif.req = 4'b0001;
    set_wd(0, 8'h77);
    serve(0, 8'h77, 16'hFFFF, 1'b1);
    bif.req = 4'b0010;
    set_wd(1, 8'h88);
    serve(1, 8'h88, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("sat_post", 32'(bif.wr_count), 32'hFFFF);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
